// File: rtl/lap_recall_ctrl.sv
// lap_recall_ctrl
//   Lap capture / recall controller between the BCD stopwatch counter and the
//   4-digit display mux. Chooses each cycle between the live count, a frozen
//   lap snapshot, or an entry recalled from a DEPTH-entry circular lap buffer.
//
// Ports
//   clk, reset (async, active-low)
//   lap_pulse, recall_pulse, clear_pulse : one-cycle synchronized requests
//   running                              : counter enabled
//   live_min/tsec/sec/tenth              : live BCD digits
//   disp_min/tsec/sec/tenth              : registered display digits
//   disp_live, disp_hold, lap_age        : display mode flags
//   lap_count, overflow                  : buffer fill level, sticky overwrite flag
//
// state    | meaning
// ---------+-----------------------------------------------
// S_LIVE   | display tracks the live count
// S_FROZEN | display holds the most recent capture
// S_RECALL | display steps back through stored laps (rd_age)
module lap_recall_ctrl #(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lap_pulse,
  input  logic          recall_pulse,
  input  logic          clear_pulse,
  input  logic          running,
  input  logic [3:0]    live_min,
  input  logic [3:0]    live_tsec,
  input  logic [3:0]    live_sec,
  input  logic [3:0]    live_tenth,
  output logic [3:0]    disp_min,
  output logic [3:0]    disp_tsec,
  output logic [3:0]    disp_sec,
  output logic [3:0]    disp_tenth,
  output logic          disp_live,
  output logic          disp_hold,
  output logic [IW-1:0] lap_age,
  output logic [IW:0]   lap_count,
  output logic          overflow
);

  typedef enum logic [1:0] {S_LIVE, S_FROZEN, S_RECALL} state_t;

  localparam logic [IW:0]   FULL     = (IW+1)'(DEPTH);
  localparam logic [IW:0]   CNT_ONE  = (IW+1)'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state, nstate;
  logic [15:0]   lap_mem [DEPTH];
  logic [IW-1:0] wr_ptr, n_wr_ptr;
  logic [IW-1:0] rd_age, n_rd_age;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   n_count;
  logic          n_overflow;
  logic          capture;
  logic [15:0]   live_word, rd_word, n_disp;

  assign live_word = {live_min, live_tsec, live_sec, live_tenth};

  always_comb begin
    nstate     = state;
    n_wr_ptr   = wr_ptr;
    n_rd_age   = rd_age;
    n_count    = lap_count;
    n_overflow = overflow;
    capture    = 1'b0;
    if (clear_pulse) begin
      nstate     = S_LIVE;
      n_wr_ptr   = '0;
      n_count    = '0;
      n_overflow = 1'b0;
      n_rd_age   = '0;
    end else begin
      case (state)
        S_LIVE: begin
          // a lap pulse swallows a simultaneous recall even when it is ignored
          if (lap_pulse) begin
            if (running) begin
              capture = 1'b1;
              nstate  = S_FROZEN;
            end
          end else if (recall_pulse && !running && lap_count != '0) begin
            nstate   = S_RECALL;
            n_rd_age = '0;
          end
        end
        S_FROZEN: begin
          if (lap_pulse) begin
            if (running) capture = 1'b1;
            else         nstate  = S_LIVE;
          end else if (recall_pulse && !running) begin
            nstate   = S_RECALL;
            n_rd_age = '0;
          end
        end
        S_RECALL: begin
          if (lap_pulse || running) begin
            nstate   = S_LIVE;
            n_rd_age = '0;
          end else if (recall_pulse) begin
            if ({1'b0, rd_age} == lap_count - CNT_ONE) begin
              nstate   = S_LIVE;
              n_rd_age = '0;
            end else begin
              n_rd_age = rd_age + IDX_ONE;
            end
          end
        end
        default: begin
          nstate   = S_LIVE;
          n_rd_age = '0;
        end
      endcase
      if (capture) begin
        n_wr_ptr = wr_ptr + IDX_ONE;
        if (lap_count == FULL) n_overflow = 1'b1;
        else                   n_count    = lap_count + CNT_ONE;
      end
    end
  end

  // Display is computed from the next state so it lands on the same edge as
  // the state change; an entry being written this cycle is bypassed from live.
  always_comb begin
    rd_idx  = n_wr_ptr - IDX_ONE - ((nstate == S_RECALL) ? n_rd_age : '0);
    rd_word = (capture && rd_idx == wr_ptr) ? live_word : lap_mem[rd_idx];
    n_disp  = (nstate == S_LIVE) ? live_word : rd_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_LIVE;
      wr_ptr    <= '0;
      rd_age    <= '0;
      lap_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= nstate;
      wr_ptr    <= n_wr_ptr;
      rd_age    <= n_rd_age;
      lap_count <= n_count;
      overflow  <= n_overflow;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) lap_mem[i] <= '0;
    end else if (capture) begin
      lap_mem[wr_ptr] <= live_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {disp_min, disp_tsec, disp_sec, disp_tenth} <= '0;
      disp_live <= 1'b1;
      disp_hold <= 1'b0;
      lap_age   <= '0;
    end else begin
      {disp_min, disp_tsec, disp_sec, disp_tenth} <= n_disp;
      disp_live <= (nstate == S_LIVE);
      disp_hold <= (nstate != S_LIVE);
      lap_age   <= (nstate == S_RECALL) ? n_rd_age : '0;
    end
  end

endmodule

// File: tb/tb_lap_recall_ctrl.sv
module tb_lap_recall_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       lap_pulse, recall_pulse, clear_pulse, running;
  logic [3:0] live_min, live_tsec, live_sec, live_tenth;
  logic [3:0] disp_min, disp_tsec, disp_sec, disp_tenth;
  logic       disp_live, disp_hold, overflow;
  logic [1:0] lap_age;
  logic [2:0] lap_count;

  int checks = 0;
  int errors = 0;

  // {digits[15:0], disp_live, disp_hold, lap_age[1:0], lap_count[2:0], overflow}
  logic [23:0] obs;
  assign obs = {disp_min, disp_tsec, disp_sec, disp_tenth,
                disp_live, disp_hold, lap_age, lap_count, overflow};

  lap_recall_ctrl #(.DEPTH(4), .IW(2)) dut (
    .clk(clk), .reset(reset),
    .lap_pulse(lap_pulse), .recall_pulse(recall_pulse),
    .clear_pulse(clear_pulse), .running(running),
    .live_min(live_min), .live_tsec(live_tsec),
    .live_sec(live_sec), .live_tenth(live_tenth),
    .disp_min(disp_min), .disp_tsec(disp_tsec),
    .disp_sec(disp_sec), .disp_tenth(disp_tenth),
    .disp_live(disp_live), .disp_hold(disp_hold),
    .lap_age(lap_age), .lap_count(lap_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [15:0] v);
    {live_min, live_tsec, live_sec, live_tenth} = v;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lap_pulse = 0; recall_pulse = 0; clear_pulse = 0; running = 0;
    set_live(16'h0000);
    repeat (2) step();
    checks++;
    if (obs !== {16'h0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs, {16'h0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_live();
    running = 1; set_live(16'h1234);
    step();
    checks++;
    if (obs !== {16'h1234, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL live_track got %h exp %h", obs, {16'h1234, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_freeze();
    set_live(16'h0050); lap_pulse = 1;
    step();
    lap_pulse = 0;
    checks++;
    if (obs !== {16'h0050, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL freeze_first got %h exp %h", obs, {16'h0050, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    end
    set_live(16'h0099);
    step();
    checks++;
    if (obs !== {16'h0050, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL freeze_hold got %h exp %h", obs, {16'h0050, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    end
    set_live(16'h0123); lap_pulse = 1;
    step();
    lap_pulse = 0;
    checks++;
    if (obs !== {16'h0123, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0}) begin
      errors++; $display("FAIL freeze_second got %h exp %h", obs, {16'h0123, 1'b0, 1'b1, 2'd0, 3'd2, 1'b0});
    end
    running = 0; set_live(16'h0130); lap_pulse = 1;
    step();
    lap_pulse = 0;
    checks++;
    if (obs !== {16'h0130, 1'b1, 1'b0, 2'd0, 3'd2, 1'b0}) begin
      errors++; $display("FAIL frozen_lap_stopped got %h exp %h", obs, {16'h0130, 1'b1, 1'b0, 2'd0, 3'd2, 1'b0});
    end
  endtask

  task automatic test_overflow_recall();
    logic [15:0] exp_disp [4];
    exp_disp[0] = 16'h0050; exp_disp[1] = 16'h0040;
    exp_disp[2] = 16'h0030; exp_disp[3] = 16'h0020;
    clear_pulse = 1;
    step();
    clear_pulse = 0;
    checks++;
    if (obs !== {16'h0130, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL clear_live got %h exp %h", obs, {16'h0130, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
    // five back-to-back laps, 0:01.0 .. 0:05.0
    running = 1; lap_pulse = 1;
    set_live(16'h0010); step();
    set_live(16'h0020); step();
    set_live(16'h0030); step();
    set_live(16'h0040); step();
    checks++;
    if (obs !== {16'h0040, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0}) begin
      errors++; $display("FAIL fill_four got %h exp %h", obs, {16'h0040, 1'b0, 1'b1, 2'd0, 3'd4, 1'b0});
    end
    set_live(16'h0050); step();
    lap_pulse = 0;
    checks++;
    if (obs !== {16'h0050, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1}) begin
      errors++; $display("FAIL overflow_set got %h exp %h", obs, {16'h0050, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1});
    end
    running = 0;
    step();
    recall_pulse = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (obs !== {exp_disp[i], 1'b0, 1'b1, 2'(i), 3'd4, 1'b1}) begin
        errors++; $display("FAIL recall_%0d got %h exp %h", i, obs, {exp_disp[i], 1'b0, 1'b1, 2'(i), 3'd4, 1'b1});
      end
    end
    step();
    recall_pulse = 0;
    checks++;
    if (obs !== {16'h0050, 1'b1, 1'b0, 2'd0, 3'd4, 1'b1}) begin
      errors++; $display("FAIL recall_wrap_live got %h exp %h", obs, {16'h0050, 1'b1, 1'b0, 2'd0, 3'd4, 1'b1});
    end
  endtask

  task automatic test_clear_recall();
    recall_pulse = 1;
    step();
    checks++;
    if (obs !== {16'h0050, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1}) begin
      errors++; $display("FAIL live_to_recall got %h exp %h", obs, {16'h0050, 1'b0, 1'b1, 2'd0, 3'd4, 1'b1});
    end
    clear_pulse = 1;
    step();
    clear_pulse = 0;
    checks++;
    if (obs !== {16'h0050, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL clear_beats_recall got %h exp %h", obs, {16'h0050, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
    step();
    recall_pulse = 0;
    checks++;
    if (obs !== {16'h0050, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL recall_empty_ignored got %h exp %h", obs, {16'h0050, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
  endtask

  task automatic test_lap_recall_same();
    running = 1; set_live(16'h0077); lap_pulse = 1; recall_pulse = 1;
    step();
    lap_pulse = 0; recall_pulse = 0;
    checks++;
    if (obs !== {16'h0077, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL lap_beats_recall got %h exp %h", obs, {16'h0077, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    end
    running = 0; recall_pulse = 1;
    step();
    recall_pulse = 0;
    checks++;
    if (obs !== {16'h0077, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL frozen_to_recall got %h exp %h", obs, {16'h0077, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    end
    running = 1;
    step();
    checks++;
    if (obs !== {16'h0077, 1'b1, 1'b0, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL recall_running_exit got %h exp %h", obs, {16'h0077, 1'b1, 1'b0, 2'd0, 3'd1, 1'b0});
    end
    running = 0; set_live(16'h0088); lap_pulse = 1;
    step();
    lap_pulse = 0;
    checks++;
    if (obs !== {16'h0088, 1'b1, 1'b0, 2'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL lap_stopped_ignored got %h exp %h", obs, {16'h0088, 1'b1, 1'b0, 2'd0, 3'd1, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    running = 1; lap_pulse = 1;
    set_live(16'h0101); step();
    set_live(16'h0202); step();
    checks++;
    if (obs !== {16'h0202, 1'b0, 1'b1, 2'd0, 3'd3, 1'b0}) begin
      errors++; $display("FAIL pre_reset got %h exp %h", obs, {16'h0202, 1'b0, 1'b1, 2'd0, 3'd3, 1'b0});
    end
    #1 reset = 1'b0;
    #2;
    checks++;
    if (obs !== {16'h0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs, {16'h0000, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
    step();
    lap_pulse = 0;
    reset = 1'b1;
    set_live(16'h0303);
    step();
    checks++;
    if (obs !== {16'h0303, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL post_reset got %h exp %h", obs, {16'h0303, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_live();
    test_freeze();
    test_overflow_recall();
    test_clear_recall();
    test_lap_recall_same();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lap_recall_ctrl.md
# lap_recall_ctrl

Lap-capture and recall controller for the stopwatch display path. It sits between the BCD stopwatch counter and the 4-digit display multiplexer. It decides each cycle whether the display shows the live count, a frozen lap snapshot, or an entry recalled from a DEPTH-entry circular lap buffer. It sequences captures, buffer pointers, and recall stepping from single-cycle button pulses supplied by the existing debounce/stopwatch logic.

## Interface
- DEPTH, 4: lap buffer entries; power of two, 2..16.
- IW, 2: index width, log2(DEPTH).
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately.
- lap_pulse  in  1  one-cycle lap request, synchronized.
- recall_pulse  in  1  one-cycle recall-step request, synchronized.
- clear_pulse  in  1  one-cycle counter-clear indication; same pulse that zeroes the counter.
- running  in  1  high while the counter is enabled (up or down).
- live_min, live_tsec, live_sec, live_tenth  in  4 each  live BCD digits from the counter.
- disp_min, disp_tsec, disp_sec, disp_tenth  out  4 each  digits to the display mux, registered.
- disp_live  out  1  high when the display digits track the live count.
- disp_hold  out  1  high in FROZEN or RECALL; drives the blink enable.
- lap_age  out  IW  age of the shown recalled entry (0 = newest); 0 outside RECALL.
- lap_count  out  IW+1  number of valid entries, saturating at DEPTH.
- overflow  out  1  sticky; set when a capture overwrites a valid entry.

## Operation
- Storage: DEPTH × 16-bit register array, write pointer wr_ptr (IW bits), lap_count, and read age rd_age.
- States: LIVE, FROZEN, RECALL.
- Event priority per cycle: clear_pulse > lap_pulse > recall_pulse. A lower-priority pulse in the same cycle is dropped, not deferred.
- Capture:
  - Writes {live_min, live_tsec, live_sec, live_tenth} sampled in the pulse cycle to entry wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - lap_count increments, saturating at DEPTH. If lap_count was already DEPTH, overflow is set.
- Transitions:
  - Any state + clear_pulse -> LIVE. Sets wr_ptr=0, lap_count=0, overflow=0, rd_age=0. Buffer contents are not erased but become invalid.
  - LIVE + lap_pulse & running -> capture; FROZEN.
  - LIVE + lap_pulse & !running -> ignored.
  - LIVE + recall_pulse & !running & lap_count>0 -> RECALL, rd_age=0.
  - FROZEN + lap_pulse & running -> capture; stay FROZEN, showing the new entry.
  - FROZEN + lap_pulse & !running -> LIVE.
  - FROZEN + recall_pulse & !running -> RECALL, rd_age=0.
  - RECALL + recall_pulse: if rd_age = lap_count-1 -> LIVE, else rd_age+1.
  - RECALL + lap_pulse -> LIVE; no capture.
  - RECALL + running=1 -> LIVE. Level-sensitive; checked after clear and lap.
- Display source:
  - LIVE: live digits.
  - FROZEN: entry (wr_ptr-1) mod DEPTH.
  - RECALL: entry (wr_ptr-1-rd_age) mod DEPTH.
- Output flags: disp_live=1 only in LIVE. disp_hold=1 in FROZEN and RECALL. lap_age=rd_age in RECALL, else 0.

## Timing
- Reset values: state LIVE, all disp_* = 0, disp_live=1, disp_hold=0, lap_age=0, lap_count=0, overflow=0, wr_ptr=0.
- All outputs are registered with one-cycle latency.
  - In LIVE, disp_* at edge n+1 equals the live_* inputs at edge n.
  - After a capture at edge n, disp_* shows the captured value from edge n+1 and is held.
- A state change at edge n is visible on disp_live, disp_hold, and lap_age at edge n+1.
- lap_count and overflow update at the same edge as the write.
- A write and a read of the same entry in one cycle return the new data (write-through bypass).
- Reset asserted mid-operation returns to reset values asynchronously. No capture completes after reset asserts.
- Back-to-back lap_pulse on consecutive cycles while running produces two captures.

## Test plan
- Reset, then drive live=1:23.4 with running=1 -> disp=1:23.4 one cycle later; disp_live=1; lap_count=0.
- Running, lap at 0:05.0, then live advances to 0:09.9 -> disp holds 0:05.0, disp_hold=1, lap_count=1. Lap again at 0:12.3 -> disp=0:12.3, lap_count=2.
- Capture 5 laps (0:01.0…0:05.0) with DEPTH=4 -> lap_count=4, overflow=1. Then stop and recall 4 times:
  - disp shows 0:05.0, 0:04.0, 0:03.0, 0:02.0 with lap_age 0..3.
  - A 5th recall -> LIVE, disp_live=1.
- In RECALL, assert clear_pulse and recall_pulse in the same cycle -> LIVE, lap_count=0, overflow=0; a following recall is ignored.
- lap_pulse and recall_pulse together in LIVE while running at 0:07.7 -> capture 0:07.7, FROZEN, no recall.
- Assert reset (low) in FROZEN with lap_count=3 -> all outputs return to reset values before the next clk edge.
